// File: rtl/decoder.sv
// Enable-gated binary-to-one-hot decoder with an optional output register.
// With REGISTERED=0 the decode reaches Y/valid combinationally and clk/rst_n are ignored.
module decoder #(
    parameter int SEL_W      = 2,
    parameter int REGISTERED = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        A,
    input  logic                    E,
    output logic [(2**SEL_W)-1:0]   Y,
    output logic                    valid
);

    localparam int OUT_W = 2**SEL_W;

    logic [OUT_W-1:0] y_next_p0;
    logic             vld_p0;

    // Decode stage: an X/Z select with E=1 propagates X through the compare,
    // so the whole output goes X in simulation and the caller fault is visible.
    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign y_next_p0[i] = E & (A == SEL_W'(i));
    end

    assign vld_p0 = E;

    if (REGISTERED != 0) begin : g_reg
        // Output stage: one-cycle latency, cleared asynchronously by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                Y     <= '0;
                valid <= 1'b0;
            end else begin
                Y     <= y_next_p0;
                valid <= vld_p0;
            end
        end
    end else begin : g_comb
        assign Y     = y_next_p0;
        assign valid = vld_p0;
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
    end

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: registered 2-bit instance (vector table, reset corners, random vs model)
// and a combinational 3-bit instance swept exhaustively.
module tb_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic       e;
    logic [3:0] y;
    logic       v;

    logic [2:0] a3;
    logic       e3;
    logic [7:0] y3;
    logic       v3;

    int checks   = 0;
    int failures = 0;

    decoder #(.SEL_W(2), .REGISTERED(1)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .E(e), .Y(y), .valid(v)
    );

    decoder #(.SEL_W(3), .REGISTERED(0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .A(a3), .E(e3), .Y(y3), .valid(v3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: one-hot of the select when enabled, zero otherwise.
    function automatic logic [31:0] ref_onehot(input int sel, input bit en);
        return en ? (32'd1 << sel) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] a;
        logic       e;
        int         hold;
        logic [3:0] y;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int exp_y;
        bit ren;
        int rsel;

        vecs.push_back('{2'b01, 1'b1, 3, 4'b0010, 1'b1});
        vecs.push_back('{2'b00, 1'b1, 20, 4'b0001, 1'b1});
        vecs.push_back('{2'b10, 1'b1, 20, 4'b0100, 1'b1});
        vecs.push_back('{2'b11, 1'b1, 20, 4'b1000, 1'b1});
        vecs.push_back('{2'b11, 1'b0, 2, 4'b0000, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 1, 4'b0000, 1'b0});
        vecs.push_back('{2'b01, 1'b0, 1, 4'b0000, 1'b0});
        vecs.push_back('{2'b10, 1'b0, 1, 4'b0000, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 2, 4'b1000, 1'b1});

        rst_n = 1'b1;
        a = 2'b11;
        e = 1'b1;
        a3 = 3'd0;
        e3 = 1'b0;
        tick();
        tick();
        check("pre_reset_y", 32'(y), 32'b1000);

        // Reset asserted between edges must clear outputs with no clock edge.
        #2;
        a = 2'b01;
        e = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_async_y", 32'(y), 32'd0);
        check("reset_async_valid", 32'(v), 32'd0);

        // Combinational instance ignores reset; sweep it while rst_n is low.
        for (int i = 0; i < 8; i++) begin
            a3 = 3'(i);
            e3 = 1'b1;
            #1;
            check("comb_y_en", 32'(y3), ref_onehot(i, 1'b1));
            check("comb_valid_en", 32'(v3), 32'd1);
            e3 = 1'b0;
            #1;
            check("comb_y_dis", 32'(y3), 32'd0);
            check("comb_valid_dis", 32'(v3), 32'd0);
        end

        tick();
        check("reset_held_y", 32'(y), 32'd0);
        check("reset_held_valid", 32'(v), 32'd0);

        e = 1'b0;
        a = 2'b01;
        #2;
        rst_n = 1'b1;
        tick();
        check("release_dis_y", 32'(y), 32'd0);
        check("release_dis_valid", 32'(v), 32'd0);

        foreach (vecs[k]) begin
            a = vecs[k].a;
            e = vecs[k].e;
            for (int c = 0; c < vecs[k].hold; c++) begin
                tick();
                check("vec_y", 32'(y), 32'(vecs[k].y));
                check("vec_valid", 32'(v), 32'(vecs[k].v));
            end
        end

        // Mid-operation asynchronous reset pulse, then resume on the next edge.
        check("midrst_pre_y", 32'(y), 32'b1000);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async_y", 32'(y), 32'd0);
        check("midrst_async_valid", 32'(v), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_still_clear_y", 32'(y), 32'd0);
        tick();
        check("midrst_resume_y", 32'(y), 32'b1000);
        check("midrst_resume_valid", 32'(v), 32'd1);

        // Randomised stream with occasional asynchronous reset pulses.
        for (int n = 0; n < 300; n++) begin
            rsel = int'($urandom_range(0, 3));
            ren = bit'($urandom_range(0, 1));
            a = 2'(rsel);
            e = ren;
            if ($urandom_range(0, 15) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rand_async_rst_y", 32'(y), 32'd0);
                check("rand_async_rst_valid", 32'(v), 32'd0);
                rst_n = 1'b1;
            end
            exp_y = int'(ref_onehot(rsel, ren));
            tick();
            check("rand_y", 32'(y), 32'(exp_y));
            check("rand_valid", 32'(v), 32'(ren));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
